// File: rtl/rptr_empty_lvl_pkg.sv
// Shared helpers for the gray-pointer FIFO controllers: pointer code conversion.
// Functions take zero-extended pointers, so one definition serves any pointer width.
package rptr_empty_lvl_pkg;

    localparam int MAX_PTR_W      = 16;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int PTR_W          = DEF_ADDR_WIDTH + 1;

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
        return (bin >> 1'b1) ^ bin;
    endfunction

    // Leading zeros of a zero-extended gray code decode to zeros, so no width argument is needed.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_ff_n.sv
// Reset-to-zero multi-flop synchronizer chain for gray pointers crossing clock domains.
module sync_ff_n #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain_r [STAGES];

    // Shift the incoming pointer through the synchronizer stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_r[i] <= '0;
            end
        end else begin
            chain_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side controller of the dual-clock gray-pointer FIFO: read pointer, empty,
// read-domain fill level, almost-empty and sticky underflow.
module rptr_empty_lvl
    import rptr_empty_lvl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1
) (
    input  logic                  rclk,
    input  logic                  rst_n,
    input  logic                  rinc,
    input  logic                  uf_clr,
    input  logic [ADDR_WIDTH:0]   wptr_async,
    output logic                  ren,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  underflow
);

    localparam int                   P_W         = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]  AE_THRESH_C = P_W'(AE_THRESH);

    logic [ADDR_WIDTH:0] wptr_sync_s;
    logic [ADDR_WIDTH:0] wbin_sync_s;
    logic [ADDR_WIDTH:0] rbin_r;
    logic [ADDR_WIDTH:0] rbin_next_s;
    logic [ADDR_WIDTH:0] rgray_next_s;
    logic [ADDR_WIDTH:0] lvl_next_s;

    sync_ff_n #(
        .WIDTH  (P_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rst_n),
        .d     (wptr_async),
        .q     (wptr_sync_s)
    );

    assign ren = rinc & ~empty;

    // Next read pointer and level; the subtraction wraps modulo 2**P_W so the level survives pointer wrap.
    always_comb begin
        wbin_sync_s  = P_W'(gray2bin(MAX_PTR_W'(wptr_sync_s)));
        rbin_next_s  = rbin_r + P_W'(ren);
        rgray_next_s = P_W'(bin2gray(MAX_PTR_W'(rbin_next_s)));
        lvl_next_s   = wbin_sync_s - rbin_next_s;
    end

    // Register pointer, address and status flags.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            rbin_r       <= '0;
            rptr         <= '0;
            raddr        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rlevel       <= '0;
            underflow    <= 1'b0;
        end else begin
            rbin_r       <= rbin_next_s;
            rptr         <= rgray_next_s;
            raddr        <= rbin_next_s[ADDR_WIDTH-1:0];
            empty        <= (rgray_next_s == wptr_sync_s);
            almost_empty <= (lvl_next_s <= AE_THRESH_C);
            rlevel       <= lvl_next_s;
            // A new underflow takes priority over a clear in the same cycle.
            if (rinc & empty) begin
                underflow <= 1'b1;
            end else if (uf_clr) begin
                underflow <= 1'b0;
            end else begin
                underflow <= underflow;
            end
        end
    end

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed bench for rptr_empty_lvl with a count-based reference model checked every cycle.
module tb_rptr_empty_lvl;

    logic       rclk = 1'b0;
    logic       rst_n;
    logic       rinc;
    logic       uf_clr;
    logic [3:0] wcnt;
    logic [3:0] wptr_async;
    logic       ren;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rlevel;
    logic       underflow;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 rclk = ~rclk;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    assign wptr_async = to_gray(wcnt);

    rptr_empty_lvl #(
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2),
        .AE_THRESH   (1)
    ) dut (
        .rclk         (rclk),
        .rst_n        (rst_n),
        .rinc         (rinc),
        .uf_clr       (uf_clr),
        .wptr_async   (wptr_async),
        .ren          (ren),
        .raddr        (raddr),
        .rptr         (rptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rlevel       (rlevel),
        .underflow    (underflow)
    );

    // Reference model: write count seen after a two-edge delay, read count, level as their difference.
    logic [3:0] hist0, hist1, m_rcnt, m_lvl;
    logic       m_empty, m_ae, m_uf;
    logic       m_rd;
    logic [3:0] m_rcnt_nxt, m_lvl_nxt;

    always_comb begin
        m_rd       = rinc && !m_empty;
        m_rcnt_nxt = m_rcnt + {3'b000, m_rd};
        m_lvl_nxt  = hist1 - m_rcnt_nxt;
    end

    always @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            hist0 <= 4'd0; hist1 <= 4'd0; m_rcnt <= 4'd0; m_lvl <= 4'd0;
            m_empty <= 1'b1; m_ae <= 1'b1; m_uf <= 1'b0;
        end else begin
            hist0   <= wcnt;
            hist1   <= hist0;
            m_rcnt  <= m_rcnt_nxt;
            m_lvl   <= m_lvl_nxt;
            m_empty <= (m_lvl_nxt == 4'd0);
            m_ae    <= (m_lvl_nxt <= 4'd1);
            m_uf    <= (rinc && m_empty) ? 1'b1 : (uf_clr ? 1'b0 : m_uf);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    always @(negedge rclk) begin
        if (chk_en) begin
            chk("m_rptr",  rptr,         to_gray(m_rcnt));
            chk("m_raddr", raddr,        m_rcnt[2:0]);
            chk("m_empty", empty,        m_empty);
            chk("m_ae",    almost_empty, m_ae);
            chk("m_level", rlevel,       m_lvl);
            chk("m_uf",    underflow,    m_uf);
            chk("m_ren",   ren,          rinc && !m_empty);
        end
    end

    task automatic cyc();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        wcnt = 4'd0; rinc = 1'b0; uf_clr = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rinc = 1'b0; uf_clr = 1'b0; wcnt = 4'd0;
        cyc(); cyc();
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_level", rlevel, 0);
        chk("rst_rptr", rptr, 0);
        chk("rst_uf", underflow, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // single write appears on the third edge
        wcnt = 4'd1;
        cyc(); chk("sw_e1_empty", empty, 1);
        cyc(); chk("sw_e2_empty", empty, 1); chk("sw_e2_level", rlevel, 0);
        cyc(); chk("sw_e3_empty", empty, 0); chk("sw_e3_level", rlevel, 1); chk("sw_e3_ae", almost_empty, 1);

        // mid-clock reset with a pending read
        rinc = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr_rptr", rptr, 0); chk("mr_empty", empty, 1); chk("mr_ren", ren, 0); chk("mr_level", rlevel, 0);
        wcnt = 4'd0; rinc = 1'b0;
        cyc();
        rst_n = 1'b1;

        // burst of five
        wcnt = 4'd5;
        repeat (3) cyc();
        chk("b_level", rlevel, 5); chk("b_empty", empty, 0); chk("b_ae", almost_empty, 0);
        rinc = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("b_rd_level", rlevel, 5 - i);
            chk("b_rd_raddr", raddr, i);
            chk("b_rd_ae", almost_empty, (i >= 4) ? 1 : 0);
        end
        chk("b_end_empty", empty, 1); chk("b_end_ren", ren, 0); chk("b_end_uf", underflow, 0);

        // underflow set / clear priority
        cyc();
        chk("uf_set", underflow, 1); chk("uf_rptr", rptr, 4'b0111); chk("uf_raddr", raddr, 5);
        rinc = 1'b0; uf_clr = 1'b1;
        cyc(); chk("uf_clr", underflow, 0);
        rinc = 1'b1;
        cyc(); chk("uf_setwins", underflow, 1);
        rinc = 1'b0;
        cyc(); chk("uf_clr2", underflow, 0);
        uf_clr = 1'b0;

        // full FIFO and wrap over two fills
        do_reset();
        wcnt = 4'd8;
        repeat (3) cyc();
        chk("f_level", rlevel, 8); chk("f_empty", empty, 0); chk("f_ae", almost_empty, 0);
        rinc = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("f1_raddr", raddr, i % 8); chk("f1_level", rlevel, 8 - i);
        end
        chk("f1_empty", empty, 1); chk("f1_rptr", rptr, 4'b1100);
        rinc = 1'b0; wcnt = 4'd0;
        repeat (3) cyc();
        chk("f2_level", rlevel, 8);
        rinc = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("f2_raddr", raddr, i % 8); chk("f2_level", rlevel, 8 - i);
        end
        chk("f2_rptr", rptr, 0); chk("f2_empty", empty, 1);

        // reset during reads at level 4 with underflow set
        cyc(); chk("rr_uf", underflow, 1);
        rinc = 1'b0; wcnt = 4'd4;
        repeat (3) cyc();
        chk("rr_level", rlevel, 4);
        rinc = 1'b1;
        cyc(); chk("rr_level3", rlevel, 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rr_rptr", rptr, 0); chk("rr_empty", empty, 1); chk("rr_uf0", underflow, 0); chk("rr_ren", ren, 0);
        wcnt = 4'd0; rinc = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (4) cyc();
        chk("rr_post_empty", empty, 1); chk("rr_post_level", rlevel, 0);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
